// File: rtl/test_dout_mc_pkg.sv
// Shared types for the test_dout_mc pattern source: FSM states, generator
// modes and the helper that maps the reserved mode onto counter behaviour.
package test_dout_mc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_CNT   = 2'd0,
      MODE_LFSR  = 2'd1,
      MODE_CONST = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   function automatic mode_e norm_mode(input logic [1:0] m);
      return (m == MODE_RSVD) ? MODE_CNT : mode_e'(m);
   endfunction

endpackage

// File: rtl/test_dout_gen.sv
// One per-channel data generator: loads its start value from the run seed
// and steps as counter, Galois LFSR or constant on each advance.
module test_dout_gen
   import test_dout_mc_pkg::*;
#(
   parameter int                DWIDTH    = 16,
   parameter logic [DWIDTH-1:0] LFSR_TAPS = 16'hB400,
   parameter int                CH_IDX    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [1:0]        load_mode,
   input  logic [DWIDTH-1:0] seed,
   input  logic              advance,
   output logic [DWIDTH-1:0] value,
   output logic [DWIDTH-1:0] value_next
);

   mode_e             mode_q, mode_d;
   logic [DWIDTH-1:0] val_q, val_d;
   logic [DWIDTH-1:0] init_val;
   logic [DWIDTH-1:0] lfsr_init;

   always_comb begin
      // an all-zero LFSR would lock up, so a zero start value becomes 1
      lfsr_init = seed ^ DWIDTH'(CH_IDX);
      if (lfsr_init == '0) lfsr_init = DWIDTH'(1);

      case (norm_mode(load_mode))
         MODE_LFSR: init_val = lfsr_init;
         default:   init_val = seed + DWIDTH'(CH_IDX);
      endcase

      case (mode_q)
         MODE_LFSR:  value_next = (val_q >> 1) ^ (val_q[0] ? LFSR_TAPS : '0);
         MODE_CONST: value_next = val_q;
         default:    value_next = val_q + 1'b1;
      endcase

      mode_d = mode_q;
      val_d  = val_q;
      if (load) begin
         mode_d = norm_mode(load_mode);
         val_d  = init_val;
      end else if (advance) begin
         val_d = value_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_CNT;
         val_q  <= '0;
      end else begin
         mode_q <= mode_d;
         val_q  <= val_d;
      end
   end

   assign value = val_q;

endmodule

// File: rtl/test_dout_mc.sv
// Multi-channel test pattern source: packets of PKT_LEN words round-robin over
// CH_NUM channels. Optional dout_parity output when TEST_DOUT_MC_PARITY_EN is defined.
module test_dout_mc
   import test_dout_mc_pkg::*;
#(
   parameter int                DWIDTH    = 16,
   parameter int                CH_NUM    = 4,
   parameter int                PKT_LEN   = 8,
   parameter logic [DWIDTH-1:0] LFSR_TAPS = 16'hB400,
   localparam int               CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [DWIDTH-1:0] seed,
   input  logic [7:0]        rounds,
   input  logic              dout_ready,
   output logic [DWIDTH-1:0] dout_data,
   output logic              dout_valid,
   output logic [CHW-1:0]    dout_ch,
   output logic              dout_last,
   output logic              busy,
   output logic              done
`ifdef TEST_DOUT_MC_PARITY_EN
   ,
   output logic              dout_parity
`endif
);

   localparam int WW = $clog2(PKT_LEN);

   state_e            state_q, state_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [WW-1:0]     word_q, word_d;
   logic [7:0]        rounds_q, rounds_d;
   logic [7:0]        round_q, round_d;
   logic              stop_pend_q, stop_pend_d;
   logic [DWIDTH-1:0] dout_data_q, dout_data_d;
   logic              dout_valid_q, dout_valid_d;
   logic              dout_last_q, dout_last_d;
   logic              load;
   logic              last_ch;
   logic [CH_NUM-1:0] adv;
   logic [DWIDTH-1:0] gen_val [CH_NUM];
   logic [DWIDTH-1:0] gen_nxt [CH_NUM];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      test_dout_gen #(
         .DWIDTH    (DWIDTH),
         .LFSR_TAPS (LFSR_TAPS),
         .CH_IDX    (c)
      ) u_gen (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (load),
         .load_mode  (mode),
         .seed       (seed),
         .advance    (adv[c]),
         .value      (gen_val[c]),
         .value_next (gen_nxt[c])
      );
   end

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      word_d       = word_q;
      rounds_d     = rounds_q;
      round_d      = round_q;
      stop_pend_d  = stop_pend_q;
      dout_data_d  = dout_data_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      load         = 1'b0;
      adv          = '0;
      last_ch      = (ch_q == CHW'(CH_NUM - 1));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_RUN;
               load         = 1'b1;
               ch_d         = '0;
               word_d       = '0;
               rounds_d     = rounds;
               round_d      = '0;
               stop_pend_d  = 1'b0;
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b0;
               // channel 0 start value: seed ^ 0 == seed + 0 == seed
               dout_data_d  = (norm_mode(mode) == MODE_LFSR && seed == '0) ? DWIDTH'(1) : seed;
            end
         end

         ST_RUN: begin
            stop_pend_d = stop_pend_q | (stop && rounds_q == 8'd0);
            if (dout_valid_q && dout_ready) begin
               adv[ch_q] = 1'b1;
               if (word_q == WW'(PKT_LEN - 1)) begin
                  if ((rounds_q != 8'd0 && last_ch && round_q == rounds_q - 8'd1) ||
                      (rounds_q == 8'd0 && (stop_pend_q || stop))) begin
                     state_d      = ST_DONE;
                     dout_valid_d = 1'b0;
                     dout_data_d  = '0;
                     dout_last_d  = 1'b0;
                     ch_d         = '0;
                  end else begin
                     word_d      = '0;
                     ch_d        = last_ch ? '0 : ch_q + 1'b1;
                     round_d     = last_ch ? round_q + 8'd1 : round_q;
                     dout_last_d = 1'b0;
                     // the outgoing channel's register only updates at this edge
                     dout_data_d = (ch_d == ch_q) ? gen_nxt[ch_q] : gen_val[ch_d];
                  end
               end else begin
                  word_d      = word_q + 1'b1;
                  dout_data_d = gen_nxt[ch_q];
                  dout_last_d = (word_d == WW'(PKT_LEN - 1));
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         word_q       <= '0;
         rounds_q     <= '0;
         round_q      <= '0;
         stop_pend_q  <= 1'b0;
         dout_data_q  <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         word_q       <= word_d;
         rounds_q     <= rounds_d;
         round_q      <= round_d;
         stop_pend_q  <= stop_pend_d;
         dout_data_q  <= dout_data_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
      end
   end

   assign dout_data  = dout_data_q;
   assign dout_valid = dout_valid_q;
   assign dout_ch    = ch_q;
   assign dout_last  = dout_last_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);

`ifdef TEST_DOUT_MC_PARITY_EN
   logic dout_parity_q, dout_parity_d;

   always_comb dout_parity_d = ^dout_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_parity_q <= 1'b0;
      else        dout_parity_q <= dout_parity_d;
   end

   assign dout_parity = dout_parity_q;
`endif

endmodule
